// File: rtl/minhash_sketch.sv
// minhash_sketch: keeps the running minimum signature (and optionally the
// k-mer behind it) for each hash seed, then streams the minima out in order.
// Ports: clk, rst (async, active-high); start pulse opens a sketch;
//   sig_valid/sig_ready/sig_idx/signature/kmer/sig_last form the beat input;
//   out_valid/out_ready/out_idx/out_min/out_kmer form the readout stream;
//   busy is high outside IDLE, done pulses after the final readout transfer.
// Optional feature macro: MINHASH_KMER_CAPTURE_EN (k-mer capture registers).
module minhash_sketch #(
    parameter int HASHER_DATA_BITS = 32,
    parameter int NUM_HASHES       = 8,
    localparam int IDX_W = (NUM_HASHES > 1) ? $clog2(NUM_HASHES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        sig_valid,
    output logic                        sig_ready,
    input  logic [IDX_W-1:0]            sig_idx,
    input  logic [HASHER_DATA_BITS-1:0] signature,
    input  logic [HASHER_DATA_BITS-1:0] kmer,
    input  logic                        sig_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            out_idx,
    output logic [HASHER_DATA_BITS-1:0] out_min,
    output logic [HASHER_DATA_BITS-1:0] out_kmer,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ACCUM,
        READOUT
    } state_t;

    localparam logic [IDX_W:0]   NH   = NUM_HASHES[IDX_W:0];
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_HASHES - 1);

    state_t state, state_nx;
    logic [IDX_W-1:0] ridx, ridx_nx;
    logic done_nx;

    logic [HASHER_DATA_BITS-1:0] minr [NUM_HASHES];

    logic xfer_in, xfer_out, idx_ok, hit;

    assign sig_ready = (state == ACCUM);
    assign out_valid = (state == READOUT);
    assign busy      = (state != IDLE);
    assign out_idx   = ridx;
    assign out_min   = minr[ridx];

    assign xfer_in  = sig_valid & sig_ready;
    assign xfer_out = out_valid & out_ready;
    // sig_idx may exceed the seed count when NUM_HASHES is not a power of 2
    assign idx_ok   = ({1'b0, sig_idx} < NH);
    // strict compare: ties keep the earlier minimum and its k-mer
    assign hit      = xfer_in & idx_ok & (signature < minr[sig_idx]);

    always_comb begin
        state_nx = state;
        ridx_nx  = ridx;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = CLEAR;
            end
            CLEAR: begin
                state_nx = ACCUM;
            end
            ACCUM: begin
                if (xfer_in && sig_last) begin
                    state_nx = READOUT;
                    ridx_nx  = '0;
                end
            end
            READOUT: begin
                if (xfer_out) begin
                    if (ridx == LAST) begin
                        state_nx = IDLE;
                        ridx_nx  = '0;
                        done_nx  = 1'b1;
                    end else begin
                        ridx_nx = ridx + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ridx  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            ridx  <= ridx_nx;
            done  <= done_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_HASHES; i++) minr[i] <= '1;
        end else if (state == CLEAR) begin
            for (int i = 0; i < NUM_HASHES; i++) minr[i] <= '1;
        end else if (hit) begin
            minr[sig_idx] <= signature;
        end
    end

`ifdef MINHASH_KMER_CAPTURE_EN
    logic [HASHER_DATA_BITS-1:0] kmr [NUM_HASHES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_HASHES; i++) kmr[i] <= '0;
        end else if (state == CLEAR) begin
            for (int i = 0; i < NUM_HASHES; i++) kmr[i] <= '0;
        end else if (hit) begin
            kmr[sig_idx] <= kmer;
        end
    end

    assign out_kmer = kmr[ridx];
`else
    logic unused_kmer;
    assign unused_kmer = ^kmer;
    assign out_kmer    = '0;
`endif

endmodule

// File: tb/tb_minhash_sketch.sv
// tb_minhash_sketch: randomized and directed checks of minhash_sketch
// against a per-seed minimum model, for NUM_HASHES of 8 and 10.
module tb_minhash_sketch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start8, start10, sig_valid, sig_last, out_ready;
    logic [3:0]  bidx;
    logic [31:0] signature, kmer;

    logic        ready8, ovalid8, busy8, done8;
    logic [2:0]  oidx8;
    logic [31:0] omin8, okmer8;
    logic        ready10, ovalid10, busy10, done10;
    logic [3:0]  oidx10;
    logic [31:0] omin10, okmer10;

    minhash_sketch #(.HASHER_DATA_BITS(32), .NUM_HASHES(8)) u8 (
        .clk(clk), .rst(rst), .start(start8),
        .sig_valid(sig_valid), .sig_ready(ready8), .sig_idx(bidx[2:0]),
        .signature(signature), .kmer(kmer), .sig_last(sig_last),
        .out_valid(ovalid8), .out_ready(out_ready), .out_idx(oidx8),
        .out_min(omin8), .out_kmer(okmer8), .busy(busy8), .done(done8)
    );

    minhash_sketch #(.HASHER_DATA_BITS(32), .NUM_HASHES(10)) u10 (
        .clk(clk), .rst(rst), .start(start10),
        .sig_valid(sig_valid), .sig_ready(ready10), .sig_idx(bidx),
        .signature(signature), .kmer(kmer), .sig_last(sig_last),
        .out_valid(ovalid10), .out_ready(out_ready), .out_idx(oidx10),
        .out_min(omin10), .out_kmer(okmer10), .busy(busy10), .done(done10)
    );

    int cur = 0;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mmin [16];
    logic [31:0] mk   [16];

    logic        s_ready, s_ovalid, s_busy, s_done;
    logic [31:0] s_oidx, s_omin, s_okmer;
    assign s_ready  = (cur != 0) ? ready10  : ready8;
    assign s_ovalid = (cur != 0) ? ovalid10 : ovalid8;
    assign s_busy   = (cur != 0) ? busy10   : busy8;
    assign s_done   = (cur != 0) ? done10   : done8;
    assign s_oidx   = (cur != 0) ? {28'd0, oidx10} : {29'd0, oidx8};
    assign s_omin   = (cur != 0) ? omin10   : omin8;
    assign s_okmer  = (cur != 0) ? okmer10  : okmer8;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nh();
        return (cur != 0) ? 10 : 8;
    endfunction

    function automatic logic [31:0] ek(input int i);
`ifdef MINHASH_KMER_CAPTURE_EN
        return mk[i];
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mmin[i] = 32'hFFFF_FFFF;
            mk[i]   = 32'd0;
        end
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        if (cur != 0) start10 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start10 = 1'b0;
        chk("clear_busy", s_busy, 1);
        chk("clear_ready", s_ready, 0);
        model_clear();
        @(posedge clk); #1;
        chk("accum_ready", s_ready, 1);
    endtask

    task automatic feed(input int idx, input logic [31:0] s,
                        input logic [31:0] k, input logic l);
        bidx = idx[3:0]; signature = s; kmer = k;
        sig_last = l; sig_valid = 1'b1;
        chk("sig_ready", s_ready, 1);
        @(posedge clk); #1;
        sig_valid = 1'b0; sig_last = 1'b0;
        if (idx < nh() && s < mmin[idx]) begin
            mmin[idx] = s;
            mk[idx]   = k;
        end
        if (l) chk("first_out_valid", s_ovalid, 1);
        else   chk("accum_busy", s_busy, 1);
    endtask

    task automatic readout(input int nx, input bit toggle, input bit inject);
        int i = 0;
        int step = 0;
        int stalls = 0;
        bit r;
        while (i < nx) begin
            chk("out_valid", s_ovalid, 1);
            chk("out_idx", s_oidx, i);
            chk("out_min", s_omin, mmin[i]);
            chk("out_kmer", s_okmer, ek(i));
            chk("no_early_done", s_done, 0);
            if (toggle && step < 4) r = (step == 0 || step == 3);
            else if (stalls >= 3)   r = 1'b1;
            else                    r = 1'($urandom_range(0, 1));
            out_ready = r;
            if (inject && step == 2) begin
                if (cur != 0) start10 = 1'b1; else start8 = 1'b1;
            end
            @(posedge clk); #1;
            out_ready = 1'b0; start8 = 1'b0; start10 = 1'b0;
            step++;
            if (r) begin i++; stalls = 0; end
            else stalls++;
        end
        if (nx == nh()) begin
            chk("done_pulse", s_done, 1);
            chk("idle_busy", s_busy, 0);
            chk("idle_valid", s_ovalid, 0);
            @(posedge clk); #1;
            chk("done_once", s_done, 0);
            chk("retain_min0", s_omin, mmin[0]);
        end
    endtask

    initial begin
        rst = 1'b1; start8 = 1'b0; start10 = 1'b0;
        sig_valid = 1'b0; sig_last = 1'b0; out_ready = 1'b0;
        bidx = 4'd0; signature = 32'd0; kmer = 32'd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            cur = w;
            chk("rst_ready", s_ready, 0);
            chk("rst_valid", s_ovalid, 0);
            chk("rst_idx", s_oidx, 0);
            chk("rst_busy", s_busy, 0);
            chk("rst_done", s_done, 0);
            chk("rst_min", s_omin, 32'hFFFF_FFFF);
            chk("rst_kmer", s_okmer, 0);
        end
        rst = 1'b0;

        cur = 0;
        do_start();
        feed(3, 32'h50, 32'hA, 1'b0);
        feed(3, 32'h20, 32'hB, 1'b0);
        feed(3, 32'h20, 32'hC, 1'b1);
        readout(8, 1'b1, 1'b1);

        cur = 1;
        do_start();
        feed(9, 32'h1234, 32'h77, 1'b0);
        feed(12, 32'h1, 32'h99, 1'b0);
        feed(9, 32'h1235, 32'h78, 1'b0);
        feed(12, 32'h0, 32'h9A, 1'b1);
        readout(10, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            int nb;
            cur = t % 2;
            nb = $urandom_range(5, 30);
            do_start();
            for (int j = 0; j < nb; j++) begin
                int idx;
                logic [31:0] s;
                idx = (cur != 0) ? $urandom_range(0, 15) : $urandom_range(0, 7);
                s = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 63);
                feed(idx, s, $urandom, 1'(j == nb - 1));
            end
            readout(nh(), 1'b0, 1'b0);
        end

        cur = 0;
        do_start();
        feed(1, 32'h33, 32'h5, 1'b0);
        feed(4, 32'h44, 32'h6, 1'b1);
        readout(4, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        model_clear();
        chk("mid_rst_valid", s_ovalid, 0);
        chk("mid_rst_busy", s_busy, 0);
        chk("mid_rst_ready", s_ready, 0);
        chk("mid_rst_idx", s_oidx, 0);
        chk("mid_rst_min", s_omin, 32'hFFFF_FFFF);
        chk("mid_rst_kmer", s_okmer, 0);
        chk("mid_rst_done", s_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk("no_done_after_rst", s_done, 0);
        end
        do_start();
        feed(5, 32'h10, 32'h3, 1'b1);
        readout(8, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/minhash_sketch.md
MINHASH_SKETCH -- requirements
Module: minhash_sketch

Interface
REQ-001 SHALL have parameter HASHER_DATA_BITS, default 32, signature and min-register width.
REQ-002 SHALL have parameter NUM_HASHES, default 8, number of seeds/min registers; IDX_W = $clog2(NUM_HASHES), minimum 1.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse to begin a new sketch.
REQ-006 SHALL have port sig_valid  input  1  signature beat valid.
REQ-007 SHALL have port sig_ready  output  1  block accepts a beat.
REQ-008 SHALL have port sig_idx  input  IDX_W  seed index of the beat.
REQ-009 SHALL have port signature  input  HASHER_DATA_BITS  hasher output for this seed.
REQ-010 SHALL have port kmer  input  HASHER_DATA_BITS  k-mer that produced the signature.
REQ-011 SHALL have port sig_last  input  1  final beat of the stream.
REQ-012 SHALL have port out_valid  output  1  readout beat valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts a readout beat.
REQ-014 SHALL have port out_idx  output  IDX_W  seed index of the readout beat.
REQ-015 SHALL have port out_min  output  HASHER_DATA_BITS  minimum signature for out_idx.
REQ-016 SHALL have port out_kmer  output  HASHER_DATA_BITS  k-mer of that minimum (see Configuration).
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse after the last readout transfer.

Function
REQ-019 SHALL implement FSM states IDLE, CLEAR, ACCUM, READOUT.
REQ-020 IDLE: a start pulse SHALL move to CLEAR; start in any other state SHALL be ignored.
REQ-021 CLEAR: for one cycle, all min registers SHALL be set to all-ones and kmer registers to 0; next state ACCUM.
REQ-022 ACCUM: sig_ready SHALL be 1; it SHALL be 0 in all other states.
REQ-023 A beat SHALL transfer when sig_valid and sig_ready are both high.
REQ-024 On transfer, if signature < min[sig_idx] (unsigned, strict), min[sig_idx] and kmer[sig_idx] SHALL update on the same edge; ties SHALL keep the earlier value.
REQ-025 A beat with sig_idx >= NUM_HASHES SHALL be accepted without updating any register.
REQ-026 A transferred beat with sig_last=1 SHALL be compared like any other beat and SHALL move the FSM to READOUT with readout index 0.
REQ-027 READOUT: out_valid SHALL be 1; out_idx, out_min and out_kmer SHALL reflect the registers at the current index and hold stable while out_ready is 0.
REQ-028 On out_valid and out_ready, the index SHALL increment; the transfer at index NUM_HASHES-1 SHALL return the FSM to IDLE and pulse done for one cycle.
REQ-029 Min registers SHALL retain their values in IDLE after readout until the next CLEAR.
REQ-030 Latency: the first out_valid SHALL assert on the cycle after the sig_last transfer.

Reset
REQ-031 rst SHALL asynchronously force IDLE, sig_ready=0, out_valid=0, out_idx=0, busy=0, done=0, all min registers all-ones, all kmer registers 0, out_min all-ones and out_kmer 0.
REQ-032 Reset asserted mid-ACCUM or mid-READOUT SHALL abandon the sketch; no done pulse SHALL follow.

Configuration
REQ-033 Macro MINHASH_KMER_CAPTURE_EN SHALL control k-mer capture.
REQ-034 When MINHASH_KMER_CAPTURE_EN is defined, kmer registers SHALL exist and out_kmer SHALL carry the argmin k-mer.
REQ-035 When MINHASH_KMER_CAPTURE_EN is undefined, no kmer registers SHALL be built, kmer SHALL be ignored, and out_kmer SHALL be constant 0.

Verification
REQ-036 Reset, then a start pulse -> CLEAR for one cycle, then sig_ready=1; busy=1 from the cycle after start.
REQ-037 NUM_HASHES=8; beats on idx 3 carrying 0x50, 0x20, 0x20 (kmer 0xA, 0xB, 0xC), last on the third -> readout idx3 shows out_min=0x20 and out_kmer=0xB; all other indices show 0xFFFFFFFF.
REQ-038 A beat with sig_idx=9 while NUM_HASHES=10 (IDX_W=4) and sig_idx=12 -> idx 9 updates; idx 12 is accepted and no register changes.
REQ-039 Readout with out_ready toggling 1,0,0,1 -> outputs stay stable while stalled; 8 transfers produce a single done pulse; a start issued during READOUT has no effect.
REQ-040 rst asserted while in READOUT at idx 4 -> out_valid=0 immediately, no done pulse, and the next sketch reads all-ones for indices that receive no beats.
REQ-041 Build with MINHASH_KMER_CAPTURE_EN undefined, rerun the REQ-037 stimulus -> out_min values unchanged and out_kmer=0 on every beat.
